sram_seq_wr_rd: RTL and testbench
=================================

SRAM_SEQ_WR_RD -- requirements
Module: sram_seq_wr_rd

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter BYTE_W, default DATA_W/8: byte-lane count and mask width.
REQ-004 Parameter BANKS, default 8: SRAM bank count; BANK_W = max(1, clog2(BANKS)).
REQ-005 Parameter MEM_ADDR_W, default 10: word-index width per bank; depth 2^MEM_ADDR_W.
REQ-006 Parameter CONFLICT_POLICY, default 1: read/write scheduling mode, defined in REQ-016.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, asynchronous assert, active-low.
REQ-009 start  input  1  one-cycle request to run one write-then-read transaction.
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 done  output  1  one-cycle pulse at transaction completion.
REQ-012 wr_addr ADDR_W, wr_data DATA_W, wr_mask BYTE_W, rd_addr ADDR_W: inputs giving write address, data, byte mask and read address.
REQ-013 rd_valid  output  1  one-cycle pulse when rd_data is updated; rd_data  output  DATA_W  read result.

Function
REQ-014 Address decode for wr_addr and rd_addr: word = addr[2 +: MEM_ADDR_W]; bank = addr[2+MEM_ADDR_W +: BANK_W]; addr[1:0] and higher bits are ignored.
REQ-015 Mask is write-disable: byte i of the addressed word SHALL take wr_data[8i+:8] only when wr_mask[i]=0; bytes with mask bit 1 SHALL keep their old value.
REQ-016 CONFLICT_POLICY=1: the read SHALL always be issued the cycle after the write. CONFLICT_POLICY=0: if the read and write banks differ, both SHALL be issued in the same cycle; if they match, scheduling SHALL be as for policy 1. In both modes the read SHALL return post-write contents.
REQ-017 FSM states: IDLE, WRITE, READ, WAIT, DONE. IDLE→WRITE when start=1. At that transition wr_addr, wr_data, wr_mask and rd_addr SHALL be latched; later input changes SHALL have no effect.
REQ-018 WRITE: perform the masked write to one bank. Next state is READ; under policy 0 with different banks, the read SHALL also be issued here and the next state SHALL be WAIT.
REQ-019 READ: issue the synchronous read (1-cycle bank latency); next state WAIT.
REQ-020 WAIT: register bank output into rd_data and pulse rd_valid for exactly one cycle; next state DONE.
REQ-021 DONE: pulse done for one cycle; next state IDLE.
REQ-022 Latency with start sampled at edge N, policy 1: write at N+1, rd_valid high N+3..N+4, done high N+4..N+5. Policy 0 with different banks: one cycle less.
REQ-023 busy=1 in WRITE, READ and WAIT, and 0 in IDLE and DONE. rd_valid SHALL always precede done by exactly one cycle.
REQ-024 start while not in IDLE SHALL be ignored and SHALL NOT queue a request.
REQ-025 rd_data SHALL hold its value between transactions.
REQ-026 Bank storage is BANKS independent arrays of 2^MEM_ADDR_W x DATA_W, each with one port used per cycle.

Reset
REQ-027 While rst=0: FSM=IDLE; busy, done, rd_valid = 0; rd_data = 0; latched request registers = 0.
REQ-028 Reset mid-transaction SHALL abort it with no done pulse. A write already clocked into a bank SHALL remain.
REQ-029 Bank contents SHALL NOT be cleared by reset. The bench SHALL write each location before reading it.

Verification
REQ-030 Write 0x0000, data 0xDEADBEEF, mask 0b0000, read 0x0000 → rd_valid pulse, then done; rd_data=0xDEADBEEF.
REQ-031 Then write 0x0000, data 0x000000AA, mask 0b1110, read 0x0000 → rd_data=0xDEADBEAA.
REQ-032 Then write 0x0000, data 0xBEEF0000, mask 0b0011, read 0x0000 → rd_data=0xBEEFBEAA; done within 200 cycles of start.
REQ-033 Write 0x1004 (bank 1, word 1), data 0x12345678, mask 0; then read 0x1004 with the write to another bank → rd_data=0x12345678. Under policy 0 done SHALL occur one cycle earlier than policy 1.
REQ-034 start pulsed again while busy → ignored: exactly one done, busy timing unchanged.
REQ-035 rst asserted in READ state → busy=0, no done pulse; after release, the next transaction completes normally.

Source files
------------

// File: rtl/sram_seq_wr_rd.sv
// Banked SRAM sequencer: one masked write followed by a synchronous read per start.
// Policy 0 overlaps the read with the write when they target different banks.
module sram_seq_wr_rd #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned BYTE_W          = DATA_W / 8,
  parameter int unsigned BANKS           = 8,
  parameter int unsigned MEM_ADDR_W      = 10,
  parameter int unsigned CONFLICT_POLICY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BYTE_W-1:0] wr_mask,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned DEPTH  = 1 << MEM_ADDR_W;
  localparam bit          OVERLAP_OK = (CONFLICT_POLICY == 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic                  mem_we_c;
  logic                  mem_re_c;

  logic [MEM_ADDR_W-1:0] wr_word_q;
  logic [BANK_W-1:0]     wr_bank_q;
  logic [MEM_ADDR_W-1:0] rd_word_q;
  logic [BANK_W-1:0]     rd_bank_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic [BYTE_W-1:0]     wr_mask_q;

  logic [DATA_W-1:0]     mem [BANKS][DEPTH];
  logic [DATA_W-1:0]     mem_q;

  // Byte-offset bits and address bits above the bank field carry no meaning here.
  logic                  unused_addr;
  assign unused_addr = ^{wr_addr, rd_addr};

  // Next-state and per-cycle bank port enables.
  always_comb begin
    next_state = state;
    mem_we_c   = 1'b0;
    mem_re_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we_c = 1'b1;
        if (OVERLAP_OK && (wr_bank_q != rd_bank_q)) begin
          mem_re_c   = 1'b1;
          next_state = S_WAIT;
        end else begin
          next_state = S_READ;
        end
      end
      S_READ: begin
        mem_re_c   = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_word_q <= '0;
      wr_bank_q <= '0;
      rd_word_q <= '0;
      rd_bank_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
    end else begin
      state    <= next_state;
      busy     <= (next_state == S_WRITE) || (next_state == S_READ) || (next_state == S_WAIT);
      rd_valid <= (state == S_WAIT);
      done     <= (state == S_DONE);
      if (state == S_WAIT) rd_data <= mem_q;
      if ((state == S_IDLE) && start) begin
        wr_word_q <= wr_addr[2 +: MEM_ADDR_W];
        wr_bank_q <= wr_addr[2 + MEM_ADDR_W +: BANK_W];
        rd_word_q <= rd_addr[2 +: MEM_ADDR_W];
        rd_bank_q <= rd_addr[2 + MEM_ADDR_W +: BANK_W];
        wr_data_q <= wr_data;
        wr_mask_q <= wr_mask;
      end
    end
  end

  // Bank arrays are not reset; a set mask bit preserves that byte lane.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < BYTE_W; b++) begin
        if (!wr_mask_q[b]) mem[wr_bank_q][wr_word_q][8*b +: 8] <= wr_data_q[8*b +: 8];
      end
    end
    if (mem_re_c) mem_q <= mem[rd_bank_q][rd_word_q];
  end

endmodule

// File: tb/tb_sram_seq_wr_rd.sv
// Directed bench for sram_seq_wr_rd: both scheduling policies run side by side
// on the same stimulus, read data checked against a per-instance scoreboard queue.
module tb_sram_seq_wr_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic [15:0] rd_addr = '0;

  logic        busy1, done1, rv1;
  logic [31:0] rd_data1;
  logic        busy0, done0, rv0;
  logic [31:0] rd_data0;

  int total = 0;
  int bad   = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  sram_seq_wr_rd #(.CONFLICT_POLICY(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .rd_addr(rd_addr),
    .rd_valid(rv1), .rd_data(rd_data1)
  );

  sram_seq_wr_rd #(.CONFLICT_POLICY(0)) u_p0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .rd_addr(rd_addr),
    .rd_valid(rv0), .rd_data(rd_data0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One transaction; lat1/lat0 are expected rd_valid cycles after the start edge.
  task automatic run(input int tn, input logic [15:0] wa, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [15:0] ra, input logic [31:0] ed,
                     input int lat1, input int lat0, input bit restart);
    int rv1_at = -1, rv0_at = -1, dn1_at = -1, dn0_at = -1;
    int rv1_n = 0, rv0_n = 0, dn1_n = 0, dn0_n = 0;
    logic b1_pre = 1'bx, b1_post = 1'bx, b0_pre = 1'bx, b0_post = 1'bx;
    logic [31:0] e;
    @(negedge clk);
    wr_addr = wa; wr_data = wd; wr_mask = wm; rd_addr = ra; start = 1'b1;
    q1.push_back(ed);
    q0.push_back(ed);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        wr_addr = 16'hFFFF; wr_data = ~wd; wr_mask = ~wm; rd_addr = 16'h7FFC;
      end
      if (restart && i == 1) start = 1'b1;
      if (restart && i == 4) start = 1'b0;
      if (rv1) begin
        rv1_n++;
        if (rv1_at < 0) rv1_at = i;
        e = (q1.size() > 0) ? q1.pop_front() : 32'hxxxxxxxx;
        chk($sformatf("t%0d p1 rd_data", tn), rd_data1, e);
      end
      if (rv0) begin
        rv0_n++;
        if (rv0_at < 0) rv0_at = i;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
        chk($sformatf("t%0d p0 rd_data", tn), rd_data0, e);
      end
      if (done1) begin dn1_n++; if (dn1_at < 0) dn1_at = i; end
      if (done0) begin dn0_n++; if (dn0_at < 0) dn0_at = i; end
      if (i == lat1 - 1) b1_pre = busy1;
      if (i == lat1)     b1_post = busy1;
      if (i == lat0 - 1) b0_pre = busy0;
      if (i == lat0)     b0_post = busy0;
    end
    chk($sformatf("t%0d p1 rd_valid_count", tn), 32'(rv1_n), 32'd1);
    chk($sformatf("t%0d p0 rd_valid_count", tn), 32'(rv0_n), 32'd1);
    chk($sformatf("t%0d p1 rd_valid_cycle", tn), 32'(rv1_at), 32'(lat1));
    chk($sformatf("t%0d p0 rd_valid_cycle", tn), 32'(rv0_at), 32'(lat0));
    chk($sformatf("t%0d p1 done_count", tn), 32'(dn1_n), 32'd1);
    chk($sformatf("t%0d p0 done_count", tn), 32'(dn0_n), 32'd1);
    chk($sformatf("t%0d p1 done_cycle", tn), 32'(dn1_at), 32'(lat1 + 1));
    chk($sformatf("t%0d p0 done_cycle", tn), 32'(dn0_at), 32'(lat0 + 1));
    chk($sformatf("t%0d p1 busy_in_wait", tn), 32'(b1_pre), 32'd1);
    chk($sformatf("t%0d p1 busy_in_done", tn), 32'(b1_post), 32'd0);
    chk($sformatf("t%0d p0 busy_in_wait", tn), 32'(b0_pre), 32'd1);
    chk($sformatf("t%0d p0 busy_in_done", tn), 32'(b0_post), 32'd0);
    chk($sformatf("t%0d p1 sb_left", tn), 32'(q1.size()), 32'd0);
    chk($sformatf("t%0d p0 sb_left", tn), 32'(q0.size()), 32'd0);
  endtask

  initial begin
    int dn_seen;
    repeat (3) @(negedge clk);
    chk("reset busy1", 32'(busy1), 32'd0);
    chk("reset done1", 32'(done1), 32'd0);
    chk("reset rv1", 32'(rv1), 32'd0);
    chk("reset rd_data1", rd_data1, 32'd0);
    chk("reset busy0", 32'(busy0), 32'd0);
    chk("reset rd_data0", rd_data0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(1, 16'h0000, 32'hDEADBEEF, 4'b0000, 16'h0000, 32'hDEADBEEF, 3, 3, 1'b0);
    run(2, 16'h0000, 32'h000000AA, 4'b1110, 16'h0000, 32'hDEADBEAA, 3, 3, 1'b0);
    run(3, 16'h0000, 32'hBEEF0000, 4'b0011, 16'h0000, 32'hBEEFBEAA, 3, 3, 1'b0);
    run(4, 16'h1004, 32'h12345678, 4'b0000, 16'h1004, 32'h12345678, 3, 3, 1'b0);
    run(5, 16'h0008, 32'h0BADF00D, 4'b0000, 16'h1004, 32'h12345678, 3, 2, 1'b0);
    run(6, 16'h9004, 32'hCAFEF00D, 4'b0101, 16'h1006, 32'hCA34F078, 3, 3, 1'b1);
    run(7, 16'h2008, 32'h600DCAFE, 4'b0000, 16'h0008, 32'h0BADF00D, 3, 2, 1'b0);

    repeat (5) @(negedge clk);
    chk("hold rd_data1", rd_data1, 32'h0BADF00D);
    chk("hold rd_data0", rd_data0, 32'h0BADF00D);

    // Abort while in READ; the write already issued must survive.
    @(negedge clk);
    wr_addr = 16'h0010; wr_data = 32'h55AA55AA; wr_mask = 4'b0000; rd_addr = 16'h0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy1", 32'(busy1), 32'd0);
    chk("abort busy0", 32'(busy0), 32'd0);
    chk("abort rd_data1", rd_data1, 32'd0);
    chk("abort rv1", 32'(rv1), 32'd0);
    dn_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1 || done0) dn_seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done1 || done0) dn_seen++;
    end
    chk("abort no_done", 32'(dn_seen), 32'd0);
    chk("abort idle busy1", 32'(busy1), 32'd0);

    run(8, 16'h0014, 32'hFFFFFFFF, 4'b1111, 16'h0010, 32'h55AA55AA, 3, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
